// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampling, mid-bit sampling, start-glitch rejection,
// framing-error detection with break-hold so a low line never yields 0x00 bytes.
`timescale 1ns/1ps
module uart_receiver #(
  parameter int OVS_DIV   = 27,
  parameter int INT_WIDTH = 8
) (
  input  logic                 UART_RX_CLOCK_50,
  input  logic                 UART_RX_RESET_InLow,
  input  logic                 UART_RX_RXD_In,
  output logic [INT_WIDTH-1:0] UART_RX_DATA_OutBus,
  output logic                 UART_RX_FLAG_Out,
  output logic                 UART_RX_FRAMEERR_Out,
  output logic                 UART_RX_BUSY_Out
);

  localparam int DIV_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam int IDX_W = (INT_WIDTH > 1) ? $clog2(INT_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(OVS_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INT_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rxs;
  logic [DIV_W-1:0]     div_cnt;
  logic [3:0]           tick_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [INT_WIDTH-1:0] shift_reg;
  logic [INT_WIDTH-1:0] data_out;
  logic                 flag;
  logic                 frame_err;
  logic                 busy;
  logic                 tick;

  assign tick = (state != IDLE) && (div_cnt == DIV_MAX);

  always_ff @(posedge UART_RX_CLOCK_50 or negedge UART_RX_RESET_InLow) begin
    if (!UART_RX_RESET_InLow) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= UART_RX_RXD_In;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge UART_RX_CLOCK_50 or negedge UART_RX_RESET_InLow) begin
    if (!UART_RX_RESET_InLow) begin
      state     <= IDLE;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data_out  <= '0;
      flag      <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      flag      <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;
      if (tick) tick_cnt <= tick_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state    <= START;
            busy     <= 1'b1;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick && tick_cnt == 4'd7) begin
            tick_cnt <= '0;
            if (!rxs) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          // Non-final bits let tick_cnt wrap 15->0 so the bit grid stays phase-locked.
          if (tick && tick_cnt == 4'd15) begin
            shift_reg[bit_idx] <= rxs;
            if (bit_idx == LAST_IDX) begin
              state    <= STOP;
              tick_cnt <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick && tick_cnt == 4'd15) begin
            tick_cnt <= '0;
            if (rxs) begin
              data_out <= shift_reg;
              flag     <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK_WAIT;
            end
          end
        end
        BRK_WAIT: begin
          // Divider is forced to 0 here so an immediate new start edge begins on a clean grid.
          if (rxs) begin
            state    <= IDLE;
            busy     <= 1'b0;
            div_cnt  <= '0;
            tick_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign UART_RX_DATA_OutBus  = data_out;
  assign UART_RX_FLAG_Out     = flag;
  assign UART_RX_FRAMEERR_Out = frame_err;
  assign UART_RX_BUSY_Out     = busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: OVS_DIV=2 instance for functional steps,
// OVS_DIV=27 instance for the +/-3 % baud drift frames.
`timescale 1ns/1ps
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       rxd27;
  logic [7:0] data;
  logic       flag;
  logic       ferr;
  logic       busy;
  logic [7:0] data27;
  logic       flag27;
  logic       ferr27;
  logic       busy27;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] got_data [64];
  int         got_cyc  [64];
  int         got_n    = 0;
  int         ferr_n   = 0;
  int         wide_n   = 0;
  int         both_n   = 0;
  logic       flag_d   = 1'b0;
  logic       ferr_d   = 1'b0;
  logic [7:0] d27      [16];
  int         f27_n    = 0;
  int         e27_n    = 0;

  always #10 clk = ~clk;

  uart_receiver #(.OVS_DIV(2), .INT_WIDTH(8)) dut (
    .UART_RX_CLOCK_50    (clk),
    .UART_RX_RESET_InLow (rst_n),
    .UART_RX_RXD_In      (rxd),
    .UART_RX_DATA_OutBus (data),
    .UART_RX_FLAG_Out    (flag),
    .UART_RX_FRAMEERR_Out(ferr),
    .UART_RX_BUSY_Out    (busy)
  );

  uart_receiver #(.OVS_DIV(27), .INT_WIDTH(8)) dut27 (
    .UART_RX_CLOCK_50    (clk),
    .UART_RX_RESET_InLow (rst_n),
    .UART_RX_RXD_In      (rxd27),
    .UART_RX_DATA_OutBus (data27),
    .UART_RX_FLAG_Out    (flag27),
    .UART_RX_FRAMEERR_Out(ferr27),
    .UART_RX_BUSY_Out    (busy27)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (flag && got_n < 64) begin
      got_data[got_n] <= data;
      got_cyc[got_n]  <= cyc;
      got_n           <= got_n + 1;
    end
    if (ferr) ferr_n <= ferr_n + 1;
    if ((flag && flag_d) || (ferr && ferr_d)) wide_n <= wide_n + 1;
    if (flag && ferr) both_n <= both_n + 1;
    flag_d <= flag;
    ferr_d <= ferr;
    if (flag27 && f27_n < 16) begin
      d27[f27_n] <= data27;
      f27_n      <= f27_n + 1;
    end
    if (ferr27) e27_n <= e27_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rxd27 = v;
    else     rxd   = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop_bit,
                            input int bitlen, output int t0);
    set_line(sel, 1'b0);
    t0 = cyc;
    wait_clks(bitlen);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, b[i]);
      wait_clks(bitlen);
    end
    set_line(sel, stop_bit);
    wait_clks(bitlen);
  endtask

  initial begin
    int base;
    int eb;
    int t0;
    int ts [3];
    logic [7:0] exp3 [3];
    logic [7:0] exp27 [4];
    exp3[0] = 8'h01; exp3[1] = 8'h0A; exp3[2] = 8'h3C;
    exp27[0] = 8'hFF; exp27[1] = 8'h00; exp27[2] = 8'hFF; exp27[3] = 8'h00;

    rst_n = 1'b0;
    rxd   = 1'b1;
    rxd27 = 1'b1;
    wait_clks(5);
    check("por_data", {24'd0, data}, 32'h00);
    check("por_flag", {31'd0, flag}, 32'h0);
    check("por_busy", {31'd0, busy}, 32'h0);
    rst_n = 1'b1;
    wait_clks(40);

    // 1. reset while a frame is in progress, then 0x14
    rxd = 1'b0;
    wait_clks(32);
    rxd = 1'b1;
    wait_clks(16);
    check("t1_busy_mid", {31'd0, busy}, 32'h1);
    rst_n = 1'b0;
    wait_clks(3);
    check("t1_rst_data", {24'd0, data}, 32'h00);
    check("t1_rst_flag", {31'd0, flag}, 32'h0);
    check("t1_rst_ferr", {31'd0, ferr}, 32'h0);
    check("t1_rst_busy", {31'd0, busy}, 32'h0);
    rst_n = 1'b1;
    wait_clks(64);
    base = got_n;
    send_frame(1'b0, 8'h14, 1'b1, 32, t0);
    wait_clks(40);
    check("t1_flag_cnt", got_n - base, 32'd1);
    check("t1_data", {24'd0, data}, 32'h14);

    // 2. three back-to-back frames; flag expected 3 + 304 clocks after the line edge
    base = got_n;
    for (int i = 0; i < 3; i++) send_frame(1'b0, exp3[i], 1'b1, 32, ts[i]);
    wait_clks(40);
    check("t2_flag_cnt", got_n - base, 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_data%0d", i), {24'd0, got_data[base+i]}, {24'd0, exp3[i]});
      check_rng($sformatf("t2_lat%0d", i), got_cyc[base+i] - ts[i], 306, 308);
    end
    check("t2_wide", wide_n, 32'd0);

    // 3. start glitch of 10 clocks, then 0x55
    base = got_n;
    eb   = ferr_n;
    rxd  = 1'b0;
    wait_clks(10);
    check("t3_busy_glitch", {31'd0, busy}, 32'h1);
    rxd = 1'b1;
    wait_clks(40);
    check("t3_no_flag", got_n - base, 32'd0);
    check("t3_no_ferr", ferr_n - eb, 32'd0);
    check("t3_busy_drop", {31'd0, busy}, 32'h0);
    send_frame(1'b0, 8'h55, 1'b1, 32, t0);
    wait_clks(40);
    check("t3_flag_cnt", got_n - base, 32'd1);
    check("t3_data", {24'd0, data}, 32'h55);

    // 4. framing error with held-low line, then 0x21
    base = got_n;
    eb   = ferr_n;
    send_frame(1'b0, 8'hA5, 1'b0, 32, t0);
    wait_clks(160);
    check("t4_ferr_cnt", ferr_n - eb, 32'd1);
    check("t4_no_flag", got_n - base, 32'd0);
    check("t4_data_kept", {24'd0, data}, 32'h55);
    check("t4_busy_break", {31'd0, busy}, 32'h1);
    rxd = 1'b1;
    wait_clks(4);
    check("t4_busy_release", {31'd0, busy}, 32'h0);
    wait_clks(40);
    send_frame(1'b0, 8'h21, 1'b1, 32, t0);
    wait_clks(40);
    check("t4_flag_cnt", got_n - base, 32'd1);
    check("t4_data", {24'd0, data}, 32'h21);
    check("t4_both", both_n, 32'd0);
    check("t4_wide", wide_n, 32'd0);

    // 5. drift on the OVS_DIV=27 instance: 445 and 419 clocks per bit vs nominal 432
    for (int i = 0; i < 4; i++) begin
      send_frame(1'b1, exp27[i], 1'b1, (i < 2) ? 445 : 419, t0);
      wait_clks(900);
    end
    check("t5_flag_cnt", f27_n, 32'd4);
    check("t5_ferr_cnt", e27_n, 32'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("t5_data%0d", i), {24'd0, d27[i]}, {24'd0, exp27[i]});
    check("t5_busy", {31'd0, busy27}, 32'h0);

    // 6. reset during data bit 4 of 0x7E, then 0x33
    base = got_n;
    rxd  = 1'b0;
    wait_clks(32);
    for (int i = 0; i < 4; i++) begin
      rxd = (i == 0) ? 1'b0 : 1'b1;
      wait_clks(32);
    end
    rxd = 1'b1;
    wait_clks(16);
    check("t6_busy_mid", {31'd0, busy}, 32'h1);
    rst_n = 1'b0;
    wait_clks(3);
    check("t6_rst_data", {24'd0, data}, 32'h00);
    rst_n = 1'b1;
    wait_clks(64);
    check("t6_no_partial", got_n - base, 32'd0);
    send_frame(1'b0, 8'h33, 1'b1, 32, t0);
    wait_clks(40);
    check("t6_flag_cnt", got_n - base, 32'd1);
    check("t6_pulse_data", {24'd0, got_data[base]}, 32'h33);
    check("t6_data", {24'd0, data}, 32'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
